// File: rtl/pwm_bank_pkg.sv
// Shared constants for pwm_bank: register map, CTRL bit indices and reset values.
// The optional readback port is built only when PWM_BANK_READBACK_EN is defined.
package pwm_bank_pkg;

    localparam int unsigned ADDR_W = 7;

    localparam logic [ADDR_W-1:0] ADDR_OUT_EN    = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN    = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE  = 7'h08;
    localparam logic [ADDR_W-1:0] ADDR_TOP       = 7'h09;
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 7'h0A;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE = 7'h10;

    localparam int unsigned CTRL_RUN_BIT   = 0;
    localparam int unsigned CTRL_FORCE_BIT = 1;

    // Reset values; 16-bit constants are truncated to the counter width at use.
    localparam logic        RST_RUN    = 1'b1;
    localparam logic        RST_EN     = 1'b0;
    localparam logic [15:0] RST_TOP    = 16'hFFFF;
    localparam logic [15:0] RST_SHADOW = 16'h0000;

endpackage

// File: rtl/pwm_bank_if.sv
// Register write / readback port and PWM outputs of pwm_bank.
interface pwm_bank_if
    import pwm_bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CNT_W  = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, pwm_out, period_start
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, pwm_out, period_start
    );
endinterface

// File: rtl/pwm_bank_timebase.sv
// Prescaler and period counter shared by all channels; generates the commit
// strobe for shadow registers and the registered period_start pulse.
module pwm_bank_timebase #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             force_upd,
    input  logic [CNT_W-1:0] prescale_act,
    input  logic [CNT_W-1:0] top_act,
    output logic [CNT_W-1:0] cnt,
    output logic             commit_c,
    output logic             period_start
);
    logic [CNT_W-1:0] psc;
    logic             tick;
    logic             wrap;
    logic             start_q;

    assign tick     = run && (psc == prescale_act);
    assign wrap     = tick && (cnt == top_act);
    assign commit_c = wrap || force_upd;

    // start_q marks the first cycle at count 0; delayed once more to line up with pwm_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc          <= '0;
            cnt          <= '0;
            start_q      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            start_q      <= commit_c;
            period_start <= start_q;
            if (force_upd) begin
                psc <= '0;
                cnt <= '0;
            end else if (tick) begin
                psc <= '0;
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end else if (run) begin
                psc <= psc + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: register file, shadowed timing/duty registers and per-channel
// compare. Define PWM_BANK_READBACK_EN to build the registered readback mux.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic      clk,
    input  logic      rst,
    pwm_bank_if.slave bus
);
    logic [NUM_CH-1:0] out_en;
    logic [NUM_CH-1:0] pwm_en;
    logic [NUM_CH-1:0] duty_wr;
    logic [NUM_CH-1:0] pwm_nx;
    logic              run;
    logic [CNT_W-1:0]  prescale_sh, prescale_act, prescale_nx;
    logic [CNT_W-1:0]  top_sh, top_act, top_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  duty_sh  [NUM_CH];
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic [7:0]        wr_byte;
    logic              wr_ctrl, wr_psc, wr_top;
    logic              force_upd;
    logic              commit_c;

    assign wr_byte     = bus.wr_data[7:0];
    assign wr_ctrl     = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    assign wr_psc      = bus.wr_en && (bus.wr_addr == ADDR_PRESCALE);
    assign wr_top      = bus.wr_en && (bus.wr_addr == ADDR_TOP);
    assign force_upd   = wr_ctrl && wr_byte[CTRL_FORCE_BIT];
    // A shadow write in a commit cycle goes straight to the active register.
    assign prescale_nx = wr_psc ? bus.wr_data : prescale_sh;
    assign top_nx      = wr_top ? bus.wr_data : top_sh;

    always_comb begin
        duty_wr = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_wr[ch] = bus.wr_en && (bus.wr_addr == ADDR_DUTY_BASE + ADDR_W'(ch));
        end
    end

    // Direct registers: enables and RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en <= {NUM_CH{RST_EN}};
            pwm_en <= {NUM_CH{RST_EN}};
            run    <= RST_RUN;
        end else begin
            if (wr_ctrl) run <= wr_byte[CTRL_RUN_BIT];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.wr_en && (bus.wr_addr == ADDR_OUT_EN + ADDR_W'(ch >> 3)))
                    out_en[ch] <= wr_byte[3'(ch)];
                if (bus.wr_en && (bus.wr_addr == ADDR_PWM_EN + ADDR_W'(ch >> 3)))
                    pwm_en[ch] <= wr_byte[3'(ch)];
            end
        end
    end

    // Shadow and active timing/duty registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_sh  <= CNT_W'(RST_SHADOW);
            prescale_act <= CNT_W'(RST_SHADOW);
            top_sh       <= CNT_W'(RST_TOP);
            top_act      <= CNT_W'(RST_TOP);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_sh[ch]  <= CNT_W'(RST_SHADOW);
                duty_act[ch] <= CNT_W'(RST_SHADOW);
            end
        end else begin
            prescale_sh <= prescale_nx;
            top_sh      <= top_nx;
            if (commit_c) begin
                prescale_act <= prescale_nx;
                top_act      <= top_nx;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (duty_wr[ch]) duty_sh[ch] <= bus.wr_data;
                if (commit_c) duty_act[ch] <= duty_wr[ch] ? bus.wr_data : duty_sh[ch];
            end
        end
    end

    pwm_bank_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .force_upd    (force_upd),
        .prescale_act (prescale_act),
        .top_act      (top_act),
        .cnt          (cnt),
        .commit_c     (commit_c),
        .period_start (bus.period_start)
    );

    // Duty above TOP saturates high; otherwise high while cnt < duty.
    always_comb begin
        pwm_nx = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_nx[ch] = out_en[ch] &
                         (~pwm_en[ch] | (duty_act[ch] > top_act) | (cnt < duty_act[ch]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bus.pwm_out <= '0;
        else     bus.pwm_out <= pwm_nx;
    end

`ifdef PWM_BANK_READBACK_EN
    logic [31:0]      out_en_w, pwm_en_w;
    logic [CNT_W-1:0] rd_nx;

    assign out_en_w = 32'(out_en);
    assign pwm_en_w = 32'(pwm_en);

    always_comb begin
        rd_nx = '0;
        if (bus.rd_addr[ADDR_W-1:2] == ADDR_OUT_EN[ADDR_W-1:2])
            rd_nx = CNT_W'(out_en_w[{bus.rd_addr[1:0], 3'b000} +: 8]);
        else if (bus.rd_addr[ADDR_W-1:2] == ADDR_PWM_EN[ADDR_W-1:2])
            rd_nx = CNT_W'(pwm_en_w[{bus.rd_addr[1:0], 3'b000} +: 8]);
        else if (bus.rd_addr == ADDR_PRESCALE)
            rd_nx = prescale_sh;
        else if (bus.rd_addr == ADDR_TOP)
            rd_nx = top_sh;
        else if (bus.rd_addr == ADDR_CTRL)
            rd_nx = CNT_W'(run);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.rd_addr == ADDR_DUTY_BASE + ADDR_W'(ch)) rd_nx = duty_sh[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bus.rd_data <= '0;
        else     bus.rd_data <= rd_nx;
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^bus.rd_addr;
    assign bus.rd_data    = '0;
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Testbench for pwm_bank: directed scenarios plus random register traffic,
// checked cycle by cycle against a period-arithmetic reference model.
module tb_pwm_bank;
    import pwm_bank_pkg::*;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned CNT_W  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
    pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position in the period measured in clk cycles.
    logic [15:0] m_out_en, m_pwm_en, exp_pwm;
    bit          m_run, m_fresh, exp_start;
    int          m_psc_sh, m_psc_act, m_top_sh, m_top_act, m_pos;
    int          m_duty_sh [NUM_CH];
    int          m_duty_act[NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_period();
        return (m_psc_act + 1) * (m_top_act + 1);
    endfunction

    task automatic model_step(input bit r, input bit we, input int a, input int d);
        int  c;
        bit  commit;
        if (r) begin
            m_out_en = '0; m_pwm_en = '0; m_run = 1'b1;
            m_psc_sh = 0; m_psc_act = 0; m_top_sh = 255; m_top_act = 255;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_duty_sh[ch] = 0; m_duty_act[ch] = 0;
            end
            m_pos = 0; m_fresh = 1'b0; exp_pwm = '0; exp_start = 1'b0;
            return;
        end
        c = m_pos / (m_psc_act + 1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit raw;
            raw = (m_duty_act[ch] > m_top_act) ? 1'b1 : (c < m_duty_act[ch]);
            exp_pwm[ch] = m_out_en[ch] & (m_pwm_en[ch] ? raw : 1'b1);
        end
        exp_start = m_fresh;
        commit = (we && a == 10 && d[1]) || (m_run && m_pos == m_period() - 1);
        if (we) begin
            if (a < 2)                 for (int i = 0; i < 8; i++) m_out_en[8*a + i] = d[i];
            else if (a >= 4 && a < 6)  for (int i = 0; i < 8; i++) m_pwm_en[8*(a-4) + i] = d[i];
            else if (a == 8)           m_psc_sh = d;
            else if (a == 9)           m_top_sh = d;
            else if (a >= 16 && a < 32) m_duty_sh[a-16] = d;
        end
        if (commit) begin
            m_pos = 0; m_fresh = 1'b1;
            m_psc_act = m_psc_sh; m_top_act = m_top_sh;
            for (int ch = 0; ch < NUM_CH; ch++) m_duty_act[ch] = m_duty_sh[ch];
        end else begin
            m_fresh = 1'b0;
            if (m_run) m_pos++;
        end
        if (we && a == 10) m_run = d[0];
    endtask

    task automatic step(input bit r, input bit we, input logic [6:0] a, input logic [7:0] d);
        rst = r; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk);
        model_step(r, we, int'(a), int'(d));
        #1;
        check_eq("pwm_out", 32'(bus.pwm_out), 32'(exp_pwm));
        check_eq("period_start", 32'(bus.period_start), 32'(exp_start));
        bus.wr_en = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic measure(input int n, output int hi, output int st);
        hi = 0; st = 0;
        repeat (n) begin
            idle();
            hi += int'(bus.pwm_out[0]);
            st += int'(bus.period_start);
        end
    endtask

    task automatic check_rd(input string tag, input logic [6:0] a, input int shadow_val);
        int exp_rd;
        bus.rd_addr = a;
`ifdef PWM_BANK_READBACK_EN
        exp_rd = shadow_val;
`else
        exp_rd = 0;
`endif
        idle();
        check_eq(tag, 32'(bus.rd_data), 32'(exp_rd));
    endtask

    initial begin
        int hi, st, v;
        bit found;
        logic [6:0] a;
        logic [7:0] d;

        bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        step(1'b1, 1'b0, 7'h00, 8'h00);
        step(1'b1, 1'b0, 7'h00, 8'h00);
        check_eq("reset_pwm", 32'(bus.pwm_out), 32'h0);
        check_eq("reset_rd", 32'(bus.rd_data), 32'h0);

        // OUT_EN byte 0 with PWM_EN clear: constant high two cycles after the write
        wr(ADDR_OUT_EN, 8'hFF);
        check_eq("out_en_lag1", 32'(bus.pwm_out), 32'h0);
        idle();
        check_eq("out_en_lag2", 32'(bus.pwm_out), 32'h00FF);

        // 3 high / 7 low, period 10
        wr(ADDR_PRESCALE, 8'd0); wr(ADDR_TOP, 8'd9); wr(ADDR_DUTY_BASE, 8'd3);
        wr(ADDR_CTRL, 8'h03); wr(ADDR_PWM_EN, 8'h01);
        repeat (5) idle();
        measure(30, hi, st);
        check_eq("duty3_high", 32'(hi), 32'd9);
        check_eq("duty3_starts", 32'(st), 32'd3);

        wr(ADDR_DUTY_BASE, 8'd0); wr(ADDR_CTRL, 8'h03);
        measure(20, hi, st);
        check_eq("duty0_low", 32'(hi), 32'd0);
        wr(ADDR_DUTY_BASE, 8'd10); wr(ADDR_CTRL, 8'h03);
        measure(20, hi, st);
        check_eq("duty_full_high", 32'(hi), 32'd20);
        wr(ADDR_TOP, 8'd255); wr(ADDR_DUTY_BASE, 8'd255); wr(ADDR_CTRL, 8'h03);
        measure(256, hi, st);
        check_eq("duty255_high", 32'(hi), 32'd255);

        // Mid-period shadow write, then a write landing in the wrap cycle
        wr(ADDR_TOP, 8'd9); wr(ADDR_DUTY_BASE, 8'd3); wr(ADDR_CTRL, 8'h03);
        repeat (4) idle();
        wr(ADDR_DUTY_BASE, 8'd7);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_pos == m_period() - 1) found = 1'b1;
            else idle();
        end
        check_eq("wrap_found", 32'(found), 32'd1);
        wr(ADDR_DUTY_BASE, 8'd5);
        measure(10, hi, st);
        check_eq("wrap_write_high", 32'(hi), 32'd5);
        check_eq("wrap_write_starts", 32'(st), 32'd1);

        // Prescaled: 8 high / 12 low; freeze and resume
        wr(ADDR_PRESCALE, 8'd3); wr(ADDR_TOP, 8'd4); wr(ADDR_DUTY_BASE, 8'd2);
        wr(ADDR_CTRL, 8'h03);
        measure(20, hi, st);
        check_eq("psc_high", 32'(hi), 32'd8);
        check_eq("psc_starts", 32'(st), 32'd1);
        repeat (3) idle();
        wr(ADDR_CTRL, 8'h00);
        idle();
        v = int'(exp_pwm[0]);
        measure(15, hi, st);
        check_eq("freeze_hold", 32'(hi), 32'(15 * v));
        check_eq("freeze_starts", 32'(st), 32'd0);
        wr(ADDR_CTRL, 8'h01);
        measure(40, hi, st);
        check_eq("resume_high", 32'(hi), 32'd16);
        check_eq("resume_starts", 32'(st), 32'd2);

        // Reset in the middle of a high pulse
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle();
            if (bus.pwm_out[0] === 1'b1) found = 1'b1;
        end
        check_eq("pulse_found", 32'(found), 32'd1);
        step(1'b1, 1'b0, 7'h00, 8'h00);
        check_eq("midreset_pwm", 32'(bus.pwm_out), 32'h0);
        check_rd("rd_top", ADDR_TOP, 255);
        check_rd("rd_duty0", ADDR_DUTY_BASE, 0);
        wr(ADDR_TOP, 8'd6);
        check_rd("rd_top_shadow", ADDR_TOP, 6);
        check_rd("rd_ctrl", ADDR_CTRL, 1);

        // Random register traffic
        wr(ADDR_OUT_EN, 8'hFF); wr(ADDR_OUT_EN + 7'd1, 8'hFF);
        wr(ADDR_TOP, 8'd7); wr(ADDR_CTRL, 8'h03);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) begin
                d = 8'($urandom);
                case ($urandom_range(9))
                    0:       a = 7'($urandom_range(3));
                    1:       a = 7'(4 + $urandom_range(3));
                    2:       begin a = ADDR_PRESCALE; d = 8'($urandom_range(3)); end
                    3:       begin a = ADDR_TOP; d = 8'($urandom_range(15)); end
                    7:       begin a = ADDR_CTRL;
                                   d = {6'd0, 1'($urandom_range(3) == 0), 1'($urandom_range(4) != 0)}; end
                    8:       a = ($urandom_range(1) == 1) ? 7'(11 + $urandom_range(4))
                                                          : 7'(48 + $urandom_range(79));
                    9:       a = 7'(32 + $urandom_range(15));
                    default: begin a = 7'(16 + $urandom_range(15)); d = 8'($urandom_range(17)); end
                endcase
                wr(a, d);
            end else begin
                idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
